// File: rtl/serial_xor_decryptor_if.sv
// Handshake bundle for the serial XOR decryptor: key/ciphertext serial inputs
// and the plaintext byte valid/ready output with status flags.
interface serial_xor_decryptor_if;
    logic       key_load_en;
    logic       key_bit;
    logic       ct_valid;
    logic       ct_bit;
    logic [7:0] pt_byte;
    logic       pt_valid;
    logic       pt_ready;
    logic       msg_done;
    logic       busy;
    logic       overflow;

    modport master (
        output key_load_en, key_bit, ct_valid, ct_bit, pt_ready,
        input  pt_byte, pt_valid, msg_done, busy, overflow
    );

    modport slave (
        input  key_load_en, key_bit, ct_valid, ct_bit, pt_ready,
        output pt_byte, pt_valid, msg_done, busy, overflow
    );
endinterface

// File: rtl/serial_xor_decryptor.sv
// Deserializes an MSB-first ciphertext stream into bytes, XORs each with a
// serially loaded key and queues the plaintext in a small valid/ready FIFO.
module serial_xor_decryptor #(
    parameter int MSG_SIZE   = 128,
    parameter int KEY_SIZE   = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    serial_xor_decryptor_if.slave  bus
);
    localparam int NUM_BYTES  = MSG_SIZE / 8;
    localparam int BYTE_CNT_W = $clog2(NUM_BYTES) + 1;
    localparam int PTR_W      = $clog2(FIFO_DEPTH);
    localparam int PTR_FW     = PTR_W + 1;

    typedef enum logic [1:0] {
        IDLE,
        KEY,
        RECV
    } state_e;

    state_e                 state_q, state_d;
    logic [KEY_SIZE-1:0]    key_q, key_d;
    logic [6:0]             shreg_q, shreg_d;
    logic [2:0]             bit_cnt_q, bit_cnt_d;
    logic [BYTE_CNT_W-1:0]  byte_cnt_q, byte_cnt_d;
    logic                   msg_done_q, msg_done_d;
    logic                   overflow_q, overflow_d;
    logic [7:0]             mem_q [FIFO_DEPTH];
    logic [7:0]             mem_d [FIFO_DEPTH];
    logic [PTR_W:0]         wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]         rd_ptr_q, rd_ptr_d;

    logic       sample;
    logic       push;
    logic [7:0] push_byte;
    logic       pop;
    logic       full;
    logic       empty;
    logic       write_en;

    always_comb begin
        state_d    = state_q;
        key_d      = key_q;
        shreg_d    = shreg_q;
        bit_cnt_d  = bit_cnt_q;
        byte_cnt_d = byte_cnt_q;
        msg_done_d = 1'b0;
        sample     = 1'b0;
        push       = 1'b0;
        push_byte  = 8'h00;

        // Key shifting wins over a ciphertext bit while not receiving.
        case (state_q)
            IDLE: begin
                if (bus.key_load_en) begin
                    key_d   = {key_q[KEY_SIZE-2:0], bus.key_bit};
                    state_d = KEY;
                end else if (bus.ct_valid) begin
                    sample  = 1'b1;
                    state_d = RECV;
                end
            end
            KEY: begin
                if (bus.key_load_en) begin
                    key_d = {key_q[KEY_SIZE-2:0], bus.key_bit};
                end else begin
                    state_d = IDLE;
                end
            end
            RECV: begin
                sample = bus.ct_valid;
            end
            default: state_d = IDLE;
        endcase

        if (sample) begin
            shreg_d   = {shreg_q[5:0], bus.ct_bit};
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
                push      = 1'b1;
                push_byte = {shreg_q, bus.ct_bit} ^ key_q;
                if (byte_cnt_q == BYTE_CNT_W'(NUM_BYTES - 1)) begin
                    msg_done_d = 1'b1;
                    byte_cnt_d = '0;
                    bit_cnt_d  = 3'd0;
                    state_d    = IDLE;
                end else begin
                    byte_cnt_d = byte_cnt_q + BYTE_CNT_W'(1);
                end
            end
        end
    end

    // A push into a full FIFO still lands if the head leaves in the same cycle.
    always_comb begin
        empty      = (wr_ptr_q == rd_ptr_q);
        full       = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                     (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
        pop        = !empty && bus.pt_ready;
        write_en   = push && (!full || pop);
        overflow_d = overflow_q | (push && full && !pop);
        mem_d      = mem_q;
        if (write_en) begin
            mem_d[wr_ptr_q[PTR_W-1:0]] = push_byte;
        end
        wr_ptr_d = wr_ptr_q + PTR_FW'(write_en);
        rd_ptr_d = rd_ptr_q + PTR_FW'(pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            key_q      <= '0;
            shreg_q    <= '0;
            bit_cnt_q  <= '0;
            byte_cnt_q <= '0;
            msg_done_q <= 1'b0;
            overflow_q <= 1'b0;
            mem_q      <= '{default: '0};
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
        end else begin
            state_q    <= state_d;
            key_q      <= key_d;
            shreg_q    <= shreg_d;
            bit_cnt_q  <= bit_cnt_d;
            byte_cnt_q <= byte_cnt_d;
            msg_done_q <= msg_done_d;
            overflow_q <= overflow_d;
            mem_q      <= mem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
        end
    end

    assign bus.pt_byte  = mem_q[rd_ptr_q[PTR_W-1:0]];
    assign bus.pt_valid = !empty;
    assign bus.msg_done = msg_done_q;
    assign bus.busy     = (state_q == RECV);
    assign bus.overflow = overflow_q;
endmodule

// File: tb/tb_serial_xor_decryptor.sv
// Self-checking bench: table of ciphertext/plaintext bytes driven serially,
// expected bytes queued at drive time and compared as the FIFO pops.
module tb_serial_xor_decryptor;
    typedef struct {
        logic [7:0] ct;
        logic [7:0] pt;
    } vec_t;

    logic clk;
    logic rst;
    serial_xor_decryptor_if bus();

    serial_xor_decryptor #(
        .MSG_SIZE  (128),
        .KEY_SIZE  (8),
        .FIFO_DEPTH(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    vec_t       vec [16];
    logic [7:0] exp_q [$];
    int         checks     = 0;
    int         failures   = 0;
    int         done_count = 0;
    int         busy_low   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
        end
    endtask

    // Pops happen at the next rising edge; the head is compared half a cycle earlier.
    always @(negedge clk) begin
        if (!rst && bus.pt_valid && bus.pt_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL pop_unexpected actual=%0h expected=none", bus.pt_byte);
            end else begin
                check("pop_data", {24'h0, bus.pt_byte}, {24'h0, exp_q.pop_front()});
            end
        end
        if (!rst && bus.msg_done) done_count++;
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        bus.ct_valid    = 1'b0;
        bus.key_load_en = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic load_key(input logic [15:0] value, input int nbits, input bit with_ct);
        for (int i = nbits - 1; i >= 0; i--) begin
            bus.key_load_en = 1'b1;
            bus.key_bit     = value[i];
            bus.ct_valid    = with_ct;
            bus.ct_bit      = 1'($urandom_range(0, 1));
            tick();
        end
        bus.key_load_en = 1'b0;
        bus.ct_valid    = 1'b0;
        tick();
    endtask

    task automatic send_byte(input logic [7:0] ct, input logic [7:0] expv, input bit push_exp,
                             input bit gapped, input bit toggle, input bit first);
        int n;
        for (int i = 7; i >= 0; i--) begin
            if (gapped && !(first && i == 7) && ($urandom_range(0, 2) == 0)) begin
                n = $urandom_range(1, 5);
                bus.ct_valid = 1'b0;
                repeat (n) begin
                    tick();
                    if (!bus.busy) busy_low++;
                end
            end
            if (toggle && !(first && i == 7)) begin
                bus.key_load_en = 1'($urandom_range(0, 1));
                bus.key_bit     = 1'b0;
            end
            if (push_exp && i == 0) exp_q.push_back(expv);
            bus.ct_bit   = ct[i];
            bus.ct_valid = 1'b1;
            tick();
            bus.ct_valid = 1'b0;
        end
    endtask

    task automatic send_message(input bit raw, input bit gapped, input bit toggle);
        for (int b = 0; b < 16; b++) begin
            send_byte(vec[b].ct, raw ? vec[b].ct : vec[b].pt, 1'b1, gapped, toggle, b == 0);
        end
        bus.key_load_en = 1'b0;
    endtask

    task automatic wait_drain(input string tag);
        int n = 0;
        while ((exp_q.size() != 0 || bus.pt_valid) && n < 60) begin
            tick();
            n++;
        end
        check({tag, "_left"}, exp_q.size(), 0);
        check({tag, "_valid"}, {31'h0, bus.pt_valid}, 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_pt_byte"},  {24'h0, bus.pt_byte}, 0);
        check({tag, "_pt_valid"}, {31'h0, bus.pt_valid}, 0);
        check({tag, "_msg_done"}, {31'h0, bus.msg_done}, 0);
        check({tag, "_busy"},     {31'h0, bus.busy}, 0);
        check({tag, "_overflow"}, {31'h0, bus.overflow}, 0);
    endtask

    initial begin
        vec[0]  = '{8'h76, 8'hD3};  vec[1]  = '{8'hEE, 8'h4B};
        vec[2]  = '{8'h2A, 8'h8F};  vec[3]  = '{8'hB7, 8'h12};
        vec[4]  = '{8'h04, 8'hA1};  vec[5]  = '{8'h60, 8'hC5};
        vec[6]  = '{8'hC8, 8'h6D};  vec[7]  = '{8'h9B, 8'h3E};
        vec[8]  = '{8'hEA, 8'h4F};  vec[9]  = '{8'h04, 8'hA1};
        vec[10] = '{8'h8E, 8'h2B};  vec[11] = '{8'hC9, 8'h6C};
        vec[12] = '{8'hD8, 8'h7D};  vec[13] = '{8'h3B, 8'h9E};
        vec[14] = '{8'h8A, 8'h2F};  vec[15] = '{8'h9F, 8'h3A};

        rst = 1'b1;
        bus.key_load_en = 1'b0;
        bus.key_bit     = 1'b0;
        bus.ct_valid    = 1'b0;
        bus.ct_bit      = 1'b0;
        bus.pt_ready    = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        check_reset_outputs("reset");

        // Continuous stream, consumer always ready
        load_key(16'h00A5, 8, 1'b0);
        bus.pt_ready = 1'b1;
        done_count = 0;
        send_message(1'b0, 1'b0, 1'b0);
        check("s1_msg_done_hi", {31'h0, bus.msg_done}, 1);
        check("s1_busy_falls", {31'h0, bus.busy}, 0);
        tick();
        check("s1_msg_done_lo", {31'h0, bus.msg_done}, 0);
        wait_drain("s1_drain");
        check("s1_done_pulses", done_count, 1);
        check("s1_overflow", {31'h0, bus.overflow}, 0);

        // Backpressure: only the first four bytes survive
        apply_reset();
        load_key(16'h00A5, 8, 1'b0);
        bus.pt_ready = 1'b0;
        for (int b = 0; b < 16; b++) begin
            send_byte(vec[b].ct, vec[b].pt, b < 4, 1'b0, 1'b0, b == 0);
            if (b == 3) check("bp_ovf_before", {31'h0, bus.overflow}, 0);
            if (b == 4) check("bp_ovf_at_5th", {31'h0, bus.overflow}, 1);
        end
        check("bp_msg_done", {31'h0, bus.msg_done}, 1);
        check("bp_head", {24'h0, bus.pt_byte}, 32'hD3);
        bus.pt_ready = 1'b1;
        wait_drain("bp_drain");

        // Gaps inside bytes, 10-bit key load, key_load_en toggled during receive
        apply_reset();
        load_key(16'h03A5, 10, 1'b0);
        busy_low = 0;
        send_message(1'b0, 1'b1, 1'b1);
        wait_drain("gap_drain");
        check("gap_busy_high", busy_low, 0);
        check("gap_overflow", {31'h0, bus.overflow}, 0);

        // Key and ciphertext together in IDLE: only the key shifts
        apply_reset();
        load_key(16'h00A5, 8, 1'b1);
        check("prio_not_busy", {31'h0, bus.busy}, 0);
        send_message(1'b0, 1'b0, 1'b0);
        wait_drain("prio_drain");

        // Reset after bit 45 discards the key; raw ciphertext then passes through
        for (int b = 0; b < 5; b++) send_byte(vec[b].ct, vec[b].pt, 1'b1, 1'b0, 1'b0, b == 0);
        for (int i = 7; i >= 3; i--) begin
            bus.ct_bit   = vec[5].ct[i];
            bus.ct_valid = 1'b1;
            tick();
        end
        check("mid_busy", {31'h0, bus.busy}, 1);
        apply_reset();
        check_reset_outputs("mid_rst");
        send_message(1'b1, 1'b0, 1'b0);
        wait_drain("raw_drain");

        // Fifth push coincides with a pop of a full FIFO
        apply_reset();
        load_key(16'h00A5, 8, 1'b0);
        bus.pt_ready = 1'b0;
        for (int b = 0; b < 4; b++) send_byte(vec[b].ct, vec[b].pt, 1'b1, 1'b0, 1'b0, b == 0);
        for (int i = 7; i >= 1; i--) begin
            bus.ct_bit   = vec[4].ct[i];
            bus.ct_valid = 1'b1;
            tick();
        end
        exp_q.push_back(vec[4].pt);
        bus.ct_bit   = vec[4].ct[0];
        bus.pt_ready = 1'b1;
        tick();
        bus.ct_valid = 1'b0;
        bus.pt_ready = 1'b0;
        check("full_pp_overflow", {31'h0, bus.overflow}, 0);
        check("full_pp_head", {24'h0, bus.pt_byte}, 32'h4B);
        check("full_pp_left", exp_q.size(), 4);
        bus.pt_ready = 1'b1;
        wait_drain("full_pp_drain");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
